// File: rtl/load_store_unit_if.sv
// Word-wide memory port between the load/store unit (master) and memory (slave).
// A transfer completes in any cycle where mem_req and mem_ready are both high.
interface load_store_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store responder for the control unit's en_ls/done_ls pair: one word per
// request over a ready-handshaked port, with a bounded wait and a sticky error.
module load_store_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         en_ls,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  st_data,
  output logic               done_ls,
  output logic [DATA_W-1:0]  ld_data,
  output logic               err,
  input  logic               err_clr,
  load_store_unit_if.master  mem
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] EN_NONE  = 2'b00;
  localparam logic [1:0] EN_LOAD  = 2'b01;
  localparam logic [1:0] EN_STORE = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic              mem_req_q, mem_req_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] ld_q, ld_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              run_dropped;

  assign run_dropped = abort_q || (en_ls == EN_NONE);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    mem_req_d = mem_req_q;
    done_d    = 1'b0;
    ld_d      = ld_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_ls == EN_LOAD || en_ls == EN_STORE) begin
          req_d     = '{we: en_ls[1], addr: addr, wdata: st_data};
          mem_req_d = 1'b1;
          cnt_d     = '0;
          abort_d   = 1'b0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.mem_ready) begin
          mem_req_d = 1'b0;
          // A dropped run still lets the memory finish, but the result is discarded.
          if (run_dropped) begin
            state_d = RELEASE;
          end else begin
            if (!req_q.we) ld_d = mem.mem_rdata;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (run_dropped) begin
            state_d = RELEASE;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else if (en_ls == EN_NONE) begin
          abort_d = 1'b1;
        end
      end
      DONE:    state_d = RELEASE;
      RELEASE: if (en_ls == EN_NONE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      mem_req_q <= 1'b0;
      done_q    <= 1'b0;
      ld_q      <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
      ld_q      <= ld_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
    end
  end

  assign done_ls       = done_q;
  assign ld_data       = ld_q;
  assign err           = err_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = req_q.we;
  assign mem.mem_addr  = req_q.addr;
  assign mem.mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: per-cycle vector table for plain load/store plus
// directed sequences for held request, timeout, abort and mid-transaction reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  en_ls = 2'b00;
  logic [15:0] addr = '0;
  logic [15:0] st_data = '0;
  logic        done_ls;
  logic [15:0] ld_data;
  logic        err;
  logic        err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  load_store_unit_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

  load_store_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .en_ls   (en_ls),
    .addr    (addr),
    .st_data (st_data),
    .done_ls (done_ls),
    .ld_data (ld_data),
    .err     (err),
    .err_clr (err_clr),
    .mem     (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  en;
    logic [15:0] a;
    logic [15:0] wd;
    logic        rdy;
    logic [15:0] rd;
    logic        e_req;
    logic        e_we;
    logic        e_done;
    logic        e_err;
    logic [15:0] e_addr;
    logic [15:0] e_wd;
    logic [15:0] e_ld;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] en, input logic [15:0] a, input logic [15:0] wd,
                       input logic rdy, input logic [15:0] rd);
    en_ls            = en;
    addr             = a;
    st_data          = wd;
    mem_if.mem_ready = rdy;
    mem_if.mem_rdata = rd;
  endtask

  initial begin
    int reqc;
    int dn;
    int k;

    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;

    //          name          en     addr     wdata    rdy   rdata     req  we   done err  maddr    mwdata   ld
    vecs[0]  = '{"ld_accept",  2'b01, 16'h0040, 16'h0000, 1'b1, 16'hBEEF, 1'b1,1'b0,1'b0,1'b0,16'h0040,16'h0000,16'h0000};
    vecs[1]  = '{"ld_done",    2'b01, 16'h0040, 16'h0000, 1'b1, 16'hBEEF, 1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,16'hBEEF};
    vecs[2]  = '{"ld_release", 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'hBEEF};
    vecs[3]  = '{"ld_idle",    2'b00, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'hBEEF};
    vecs[4]  = '{"st_accept",  2'b10, 16'h1234, 16'hA5A5, 1'b0, 16'h0000, 1'b1,1'b1,1'b0,1'b0,16'h1234,16'hA5A5,16'hBEEF};
    vecs[5]  = '{"st_wait1",   2'b10, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1,1'b1,1'b0,1'b0,16'h1234,16'hA5A5,16'hBEEF};
    vecs[6]  = '{"st_wait2",   2'b10, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1,1'b1,1'b0,1'b0,16'h1234,16'hA5A5,16'hBEEF};
    vecs[7]  = '{"st_wait3",   2'b10, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1,1'b1,1'b0,1'b0,16'h1234,16'hA5A5,16'hBEEF};
    vecs[8]  = '{"st_done",    2'b10, 16'hFFFF, 16'h0000, 1'b1, 16'hDEAD, 1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000,16'hBEEF};
    vecs[9]  = '{"st_release", 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'hBEEF};
    vecs[10] = '{"st_idle",    2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'hBEEF};
    vecs[11] = '{"illegal11a", 2'b11, 16'h0300, 16'h5555, 1'b1, 16'h4444, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'hBEEF};
    vecs[12] = '{"illegal11b", 2'b11, 16'h0300, 16'h5555, 1'b1, 16'h4444, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'hBEEF};
    vecs[13] = '{"idle_none",  2'b00, 16'h0000, 16'h0000, 1'b1, 16'h4444, 1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'hBEEF};

    // reset state
    #12;
    chk("rst_done",  {15'd0, done_ls}, 16'h0000);
    chk("rst_req",   {15'd0, mem_if.mem_req}, 16'h0000);
    chk("rst_we",    {15'd0, mem_if.mem_we}, 16'h0000);
    chk("rst_err",   {15'd0, err}, 16'h0000);
    chk("rst_addr",  mem_if.mem_addr, 16'h0000);
    chk("rst_wdata", mem_if.mem_wdata, 16'h0000);
    chk("rst_ld",    ld_data, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // table: load with ready tied high, store with three wait cycles, illegal 11
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].en, vecs[i].a, vecs[i].wd, vecs[i].rdy, vecs[i].rd);
      tick();
      chk({vecs[i].nm, "_req"},  {15'd0, mem_if.mem_req}, {15'd0, vecs[i].e_req});
      chk({vecs[i].nm, "_done"}, {15'd0, done_ls}, {15'd0, vecs[i].e_done});
      chk({vecs[i].nm, "_err"},  {15'd0, err}, {15'd0, vecs[i].e_err});
      chk({vecs[i].nm, "_ld"},   ld_data, vecs[i].e_ld);
      if (vecs[i].e_req) begin
        chk({vecs[i].nm, "_we"},    {15'd0, mem_if.mem_we}, {15'd0, vecs[i].e_we});
        chk({vecs[i].nm, "_addr"},  mem_if.mem_addr, vecs[i].e_addr);
        chk({vecs[i].nm, "_wdata"}, mem_if.mem_wdata, vecs[i].e_wd);
      end
    end

    // held request: en_ls stays 01 after done_ls
    drive(2'b01, 16'h0002, 16'h0000, 1'b1, 16'h7777);
    tick(); chk("held_accept_req", {15'd0, mem_if.mem_req}, 16'h0001);
    tick(); chk("held_done", {15'd0, done_ls}, 16'h0001);
    chk("held_ld", ld_data, 16'h7777);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_no_req",  {15'd0, mem_if.mem_req}, 16'h0000);
      chk("held_no_done", {15'd0, done_ls}, 16'h0000);
    end
    en_ls = 2'b00;
    tick(); chk("held_idle_req", {15'd0, mem_if.mem_req}, 16'h0000);
    drive(2'b01, 16'h0003, 16'h0000, 1'b1, 16'h8888);
    tick(); chk("held_new_req", {15'd0, mem_if.mem_req}, 16'h0001);
    chk("held_new_addr", mem_if.mem_addr, 16'h0003);
    tick(); chk("held_new_done", {15'd0, done_ls}, 16'h0001);
    chk("held_new_ld", ld_data, 16'h8888);
    en_ls = 2'b00;
    tick(); tick();

    // timeout: TIMEOUT=8, memory never ready
    drive(2'b01, 16'h0100, 16'h0000, 1'b0, 16'h9999);
    tick();
    reqc = 0; dn = 0; k = 0;
    while (mem_if.mem_req && k < 20) begin
      reqc++;
      tick();
      if (done_ls) dn++;
      k++;
    end
    chk("to_busy_cycles", 16'(reqc), 16'd8);
    chk("to_done_at_abort", {15'd0, done_ls}, 16'h0001);
    chk("to_err", {15'd0, err}, 16'h0001);
    chk("to_ld_unchanged", ld_data, 16'h8888);
    tick(); if (done_ls) dn++;
    tick(); if (done_ls) dn++;
    chk("to_single_done", 16'(dn), 16'd1);
    en_ls = 2'b00;
    tick(); chk("to_err_sticky", {15'd0, err}, 16'h0001);
    err_clr = 1'b1;
    tick(); chk("to_err_clr", {15'd0, err}, 16'h0000);
    err_clr = 1'b0;

    // abort: run drops during BUSY, memory finishes later
    drive(2'b01, 16'h0200, 16'h0000, 1'b0, 16'h0000);
    tick(); chk("ab_req", {15'd0, mem_if.mem_req}, 16'h0001);
    en_ls = 2'b00;
    tick(); chk("ab_busy1", {15'd0, mem_if.mem_req}, 16'h0001);
    tick(); chk("ab_busy2", {15'd0, mem_if.mem_req}, 16'h0001);
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 16'h1111;
    tick(); chk("ab_req_drop", {15'd0, mem_if.mem_req}, 16'h0000);
    chk("ab_no_done", {15'd0, done_ls}, 16'h0000);
    chk("ab_ld", ld_data, 16'h8888);
    mem_if.mem_ready = 1'b0;
    tick(); chk("ab_no_done2", {15'd0, done_ls}, 16'h0000);
    drive(2'b01, 16'h0005, 16'h0000, 1'b1, 16'h2222);
    tick(); chk("ab_idle_accept", {15'd0, mem_if.mem_req}, 16'h0001);
    tick(); chk("ab_next_done", {15'd0, done_ls}, 16'h0001);
    chk("ab_next_ld", ld_data, 16'h2222);
    en_ls = 2'b00;
    tick(); tick();

    // asynchronous reset mid-BUSY
    drive(2'b01, 16'h0300, 16'h0000, 1'b0, 16'h0000);
    tick(); chk("rb_req", {15'd0, mem_if.mem_req}, 16'h0001);
    #2 reset = 1'b0;
    #1;
    chk("rb_req_drop", {15'd0, mem_if.mem_req}, 16'h0000);
    chk("rb_done", {15'd0, done_ls}, 16'h0000);
    chk("rb_ld", ld_data, 16'h0000);
    chk("rb_addr", mem_if.mem_addr, 16'h0000);
    en_ls = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    tick(); tick();
    chk("rb_idle_none", {15'd0, mem_if.mem_req}, 16'h0000);
    drive(2'b01, 16'h0301, 16'h0000, 1'b1, 16'h3333);
    tick(); chk("rb_accept", {15'd0, mem_if.mem_req}, 16'h0001);
    tick(); chk("rb_done2", {15'd0, done_ls}, 16'h0001);
    chk("rb_ld2", ld_data, 16'h3333);
    en_ls = 2'b00;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
